// File: rtl/p4_memory_access.sv
// Memory-access stage of the SIMPLE pipeline: latches one instruction, runs at most one
// req/ack data-memory transaction with timeout abort, and hands results to write-back.
module p4_memory_access #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ar_in,
    input  logic [WIDTH-1:0] dr_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [1:0]       op_res_in,
    input  logic             reg_write_in,
    input  logic [2:0]       rd_addr_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_register,
    output logic [WIDTH-1:0] mem_read_data,
    output logic [1:0]       op_res,
    output logic             reg_write,
    output logic [2:0]       rd_addr,
    output logic             mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Abort fires on the edge where the count of ack-less BUSY cycles would reach TIMEOUT.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        accept_s;
    logic        done_s;
    logic        abort_s;
    logic        mem_op_in_s;
    logic        is_load_r;
    logic [7:0]  wait_cnt_r;
    logic        mem_req_r;
    logic        out_valid_r;

    assign mem_op_in_s = mem_read_in | mem_write_in;
    assign in_ready    = (state_r == ST_IDLE) || (state_r == ST_OUT);
    assign mem_req     = mem_req_r;
    assign out_valid   = out_valid_r;

    // Next-state decode: accept, normal completion (ack wins over expiry) or timeout abort.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = mem_op_in_s ? ST_BUSY : ST_OUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_OUT;
                end else if (wait_cnt_r == TIMEOUT_M1) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_OUT: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = mem_op_in_s ? ST_BUSY : ST_OUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered request / valid strobes derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_req_r   <= (state_nxt_s == ST_BUSY);
            out_valid_r <= (state_nxt_s == ST_OUT);
        end
    end

    // Wait counter: cleared on accept, counts ack-less BUSY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (accept_s) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ST_BUSY) && !mem_ack) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Instruction fields latched on accept; they hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr      <= '0;
            mem_wdata     <= '0;
            data_register <= '0;
            mem_we        <= 1'b0;
            is_load_r     <= 1'b0;
            op_res        <= 2'd0;
            rd_addr       <= 3'd0;
        end else if (accept_s) begin
            mem_addr      <= ar_in;
            mem_wdata     <= dr_in;
            data_register <= dr_in;
            mem_we        <= mem_write_in;
            is_load_r     <= mem_read_in & ~mem_write_in;
            op_res        <= op_res_in;
            rd_addr       <= rd_addr_in;
        end else begin
            mem_addr      <= mem_addr;
            mem_wdata     <= mem_wdata;
            data_register <= data_register;
            mem_we        <= mem_we;
            is_load_r     <= is_load_r;
            op_res        <= op_res;
            rd_addr       <= rd_addr;
        end
    end

    // Result word, write enable and sticky error; an abort poisons the word and kills the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_data <= '0;
            reg_write     <= 1'b0;
            mem_err       <= 1'b0;
        end else if (accept_s) begin
            mem_read_data <= '0;
            reg_write     <= reg_write_in;
            mem_err       <= mem_err;
        end else if (done_s) begin
            mem_read_data <= is_load_r ? mem_rdata : '0;
            reg_write     <= reg_write;
            mem_err       <= mem_err;
        end else if (abort_s) begin
            mem_read_data <= '1;
            reg_write     <= 1'b0;
            mem_err       <= 1'b1;
        end else begin
            mem_read_data <= mem_read_data;
            reg_write     <= reg_write;
            mem_err       <= mem_err;
        end
    end

endmodule
